// File: rtl/pwm_dac_generator_if.sv
`default_nettype none
// ============================================================================
// Module      : pwm_dac_generator_if
// Description : Millivolt setpoint valid/ready handshake into the PWM DAC.
// Revision    : 1.0 - initial release
// ============================================================================

interface pwm_dac_generator_if;
   logic [15:0] mv_in;
   logic        mv_valid;
   logic        mv_ready;

   modport master (
      output mv_in,
      output mv_valid,
      input  mv_ready
   );

   modport slave (
      input  mv_in,
      input  mv_valid,
      output mv_ready
   );
endinterface

`default_nettype wire

// File: rtl/pwm_dac_generator.sv
`default_nettype none
// ============================================================================
// Module      : pwm_dac_generator
// Description : Converts a millivolt setpoint to a PWM duty code through a
//               clamp / multiply / shift pipeline and drives a PWM DAC pin.
//               Build option PWM_SHADOW_EN: when defined, the new duty is held
//               and loaded only at a PWM period boundary (glitch-free).
// Revision    : 1.0 - initial release
// ============================================================================

module pwm_dac_generator #(
   parameter int WIDTH          = 8,
   parameter int FULL_SCALE_MV  = 3300,
   parameter int SCALING_FACTOR = 79,
   parameter int SHIFT_FACTOR   = 10
) (
   input  logic                 clk,
   input  logic                 reset,
   pwm_dac_generator_if.slave   mv,
   output logic                 pwm_out,
   output logic [WIDTH-1:0]     duty_code,
   output logic                 period_pulse
);

   localparam int                  C_MV_W       = 16;
   localparam int                  C_PROD_W     = C_MV_W + $clog2(SCALING_FACTOR) + 1;
   localparam logic [WIDTH-1:0]    C_CNT_MAX    = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0]    C_CNT_PRE    = C_CNT_MAX - 1'b1;
   localparam logic [C_MV_W-1:0]   C_FULL_SCALE = C_MV_W'(FULL_SCALE_MV);
   localparam logic [C_PROD_W-1:0] C_SCALE      = C_PROD_W'(SCALING_FACTOR);
   localparam logic [C_PROD_W-1:0] C_DUTY_MAX   = C_PROD_W'((2 ** WIDTH) - 1);

`ifdef PWM_SHADOW_EN
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLAMP = 3'd1,
      S_MULT  = 3'd2,
      S_SHIFT = 3'd3,
      S_HOLD  = 3'd4
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLAMP = 2'd1,
      S_MULT  = 2'd2,
      S_SHIFT = 2'd3
   } state_t;
`endif

   state_t               r_state;
   state_t               w_state_next;
   logic                 w_accept;
   logic                 w_load_duty;
   logic                 w_at_max;
   logic [C_MV_W-1:0]    w_mv_clamped;
   logic [C_MV_W-1:0]    r_mv_c;
   logic [C_PROD_W-1:0]  r_prod;
   logic [C_PROD_W-1:0]  w_shifted;
   logic [WIDTH-1:0]     w_pend_sat;
   logic [WIDTH-1:0]     r_pend;
   logic [WIDTH-1:0]     r_duty;
   logic [WIDTH-1:0]     r_counter;
   logic                 r_pwm;
   logic                 r_pulse;

   // Ready is gated by reset so a source never sees a handshake during reset.
   assign mv.mv_ready   = (r_state == S_IDLE) & reset;
   assign w_accept      = mv.mv_valid & mv.mv_ready;
   assign w_at_max      = (r_counter == C_CNT_MAX);

   assign w_mv_clamped  = (mv.mv_in > C_FULL_SCALE) ? C_FULL_SCALE : mv.mv_in;
   assign w_shifted     = r_prod >> SHIFT_FACTOR;
   assign w_pend_sat    = (w_shifted > C_DUTY_MAX) ? C_CNT_MAX : w_shifted[WIDTH-1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_load_duty  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_next = S_CLAMP;
            end
         end
         S_CLAMP: begin
            w_state_next = S_MULT;
         end
         S_MULT: begin
            w_state_next = S_SHIFT;
         end
`ifdef PWM_SHADOW_EN
         // A boundary coinciding with SHIFT is skipped; the load waits a full period.
         S_SHIFT: begin
            w_state_next = S_HOLD;
         end
         S_HOLD: begin
            if (w_at_max) begin
               w_load_duty  = 1'b1;
               w_state_next = S_IDLE;
            end
         end
`else
         S_SHIFT: begin
            w_load_duty  = 1'b1;
            w_state_next = S_IDLE;
         end
`endif
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mv_c <= '0;
         r_prod <= '0;
         r_pend <= '0;
         r_duty <= '0;
      end else begin
         if (w_accept) begin
            r_mv_c <= w_mv_clamped;
         end
         if (r_state == S_CLAMP) begin
            r_prod <= C_PROD_W'(r_mv_c) * C_SCALE;
         end
         if (r_state == S_MULT) begin
            r_pend <= w_pend_sat;
         end
         if (w_load_duty) begin
            r_duty <= r_pend;
         end
      end
   end

   // Pulse is registered one count early so it lines up with counter == max.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_counter <= '0;
         r_pulse   <= 1'b0;
         r_pwm     <= 1'b0;
      end else begin
         r_counter <= r_counter + 1'b1;
         r_pulse   <= (r_counter == C_CNT_PRE);
         r_pwm     <= (r_counter < r_duty);
      end
   end

   assign pwm_out      = r_pwm;
   assign duty_code    = r_duty;
   assign period_pulse = r_pulse;

endmodule

`default_nettype wire

// File: tb/tb_pwm_dac_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_dac_generator
// Description : Self-checking bench for pwm_dac_generator (either build of
//               PWM_SHADOW_EN) against an edge-indexed behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_pwm_dac_generator;

   localparam int WIDTH  = 8;
   localparam int PERIOD = 256;
   localparam int FS     = 3300;
   localparam int SF     = 79;
   localparam int SH     = 10;

   logic             clk;
   logic             reset;
   logic             pwm_out;
   logic             period_pulse;
   logic [WIDTH-1:0] duty_code;

   pwm_dac_generator_if mv ();

   pwm_dac_generator #(
      .WIDTH          (WIDTH),
      .FULL_SCALE_MV  (FS),
      .SCALING_FACTOR (SF),
      .SHIFT_FACTOR   (SH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .mv           (mv),
      .pwm_out      (pwm_out),
      .duty_code    (duty_code),
      .period_pulse (period_pulse)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int exp_duty(input int mv_val);
      int c;
      int d;
      c = (mv_val > FS) ? FS : mv_val;
      d = (c * SF) / (2 ** SH);
      return (d > PERIOD - 1) ? PERIOD - 1 : d;
   endfunction

   // Model: m_k = clock edges since reset release; the counter is m_k mod PERIOD.
   int m_k         = 0;
   int m_duty      = 0;
   int m_pend      = 0;
   int m_load_edge = 0;
   bit m_busy      = 1'b0;
   bit m_pwm       = 1'b0;

   always @(posedge clk) begin
      if (!reset) begin
         m_k    = 0;
         m_duty = 0;
         m_pend = 0;
         m_busy = 1'b0;
         m_pwm  = 1'b0;
      end else begin
         int edge_idx;
         edge_idx = m_k + 1;
         m_pwm    = ((m_k % PERIOD) < m_duty);
         if (m_busy) begin
            if (edge_idx == m_load_edge) begin
               m_duty = m_pend;
               m_busy = 1'b0;
            end
         end else if (mv.mv_valid) begin
            m_busy = 1'b1;
            m_pend = exp_duty(int'(mv.mv_in));
`ifdef PWM_SHADOW_EN
            m_load_edge = ((edge_idx + 4 + PERIOD - 1) / PERIOD) * PERIOD;
`else
            m_load_edge = edge_idx + 3;
`endif
         end
         m_k = edge_idx;
      end
   end

   always @(posedge clk) begin
      #2;
      check("duty_code",    int'(duty_code),    m_duty);
      check("pwm_out",      int'(pwm_out),      int'(m_pwm));
      check("period_pulse", int'(period_pulse), (m_k % PERIOD == PERIOD - 1) ? 1 : 0);
      check("mv_ready",     int'(mv.mv_ready),  (reset && !m_busy) ? 1 : 0);
   end

   task automatic wait_accept();
      int n = 0;
      while (!mv.mv_ready && n < 700) begin
         @(negedge clk);
         n++;
      end
      check("accept_timeout", int'(mv.mv_ready), 1);
      @(negedge clk);
      mv.mv_valid = 1'b0;
   endtask

   task automatic send(input int v);
      mv.mv_in    = 16'(v);
      mv.mv_valid = 1'b1;
      wait_accept();
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!mv.mv_ready && n < 700) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", int'(mv.mv_ready), 1);
   endtask

   task automatic wait_counter(input int c);
      int n = 0;
      while ((m_k % PERIOD) != c && n < 600) begin
         @(negedge clk);
         n++;
      end
      check("counter_timeout", m_k % PERIOD, c);
   endtask

   task automatic count_period(output int hi, output int pulses);
      hi     = 0;
      pulses = 0;
      for (int i = 0; i < PERIOD; i++) begin
         @(negedge clk);
         hi     += int'(pwm_out);
         pulses += int'(period_pulse);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int hi;
      int pulses;
      reset       = 1'b0;
      mv.mv_valid = 1'b0;
      mv.mv_in    = '0;

      // Reset state
      repeat (5) @(negedge clk);
      check("rst_pwm_out",      int'(pwm_out),      0);
      check("rst_duty_code",    int'(duty_code),    0);
      check("rst_mv_ready",     int'(mv.mv_ready),  0);
      check("rst_period_pulse", int'(period_pulse), 0);
      reset = 1'b1;
      #1;
      check("ready_after_release", int'(mv.mv_ready), 1);
      @(negedge clk);

      // Mid-scale setpoint and PWM shape
      send(1650);
      wait_idle();
      check("duty_1650", int'(duty_code), 127);
      count_period(hi, pulses);
      check("pwm_high_1650", hi, 127);
      check("pulses_per_period", pulses, 1);

      // Full scale, clamp, zero
      send(3300);
      wait_idle();
      check("duty_3300", int'(duty_code), 254);
      count_period(hi, pulses);
      check("pwm_high_3300", hi, 254);
      send(4000);
      wait_idle();
      check("duty_4000_clamped", int'(duty_code), 254);
      send(0);
      wait_idle();
      check("duty_0", int'(duty_code), 0);
      count_period(hi, pulses);
      check("pwm_high_0", hi, 0);

      // Accept at counter 10 with a second setpoint held behind it
      wait_counter(10);
      mv.mv_in    = 16'd1000;
      mv.mv_valid = 1'b1;
      @(negedge clk);
      mv.mv_in = 16'd2000;
      check("busy_after_accept", int'(mv.mv_ready), 0);
      repeat (2) @(negedge clk);
      check("duty_old_t2", int'(duty_code), 0);
      @(negedge clk);
`ifdef PWM_SHADOW_EN
      check("duty_held_t3", int'(duty_code), 0);
      wait_counter(255);
      check("duty_before_boundary", int'(duty_code), 0);
      check("ready_in_hold", int'(mv.mv_ready), 0);
      @(negedge clk);
      check("duty_at_boundary", int'(duty_code), 77);
`else
      check("duty_direct_t3", int'(duty_code), 77);
`endif
      wait_accept();
      wait_idle();
      check("duty_second_2000", int'(duty_code), 154);

      // Reset while a setpoint is in flight
      wait_counter(20);
      send(3000);
`ifdef PWM_SHADOW_EN
      repeat (5) @(negedge clk);
`else
      @(negedge clk);
`endif
      reset = 1'b0;
      #1;
      check("midrst_duty", int'(duty_code), 0);
      check("midrst_pwm", int'(pwm_out), 0);
      check("midrst_ready", int'(mv.mv_ready), 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (300) @(negedge clk);
      check("no_stale_load", int'(duty_code), 0);

`ifndef PWM_SHADOW_EN
      // Direct load lands mid-period exactly three clocks after accept
      wait_counter(10);
      mv.mv_in    = 16'd1650;
      mv.mv_valid = 1'b1;
      @(negedge clk);
      mv.mv_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("direct_duty_t2", int'(duty_code), 0);
      @(negedge clk);
      check("direct_duty_t3", int'(duty_code), 127);
`endif

      // Randomized setpoints, back-to-back holds and occasional resets
      for (int i = 0; i < 40; i++) begin
         int v;
         int sel;
         sel = int'($urandom_range(0, 9));
         case (sel)
            0:       v = 0;
            1:       v = FS;
            2:       v = int'($urandom_range(3301, 65535));
            default: v = int'($urandom_range(0, 3300));
         endcase
         repeat ($urandom_range(0, 40)) @(negedge clk);
         if ($urandom_range(0, 9) == 0) begin
            reset = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            reset = 1'b1;
         end
         send(v);
      end
      wait_idle();
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
